// File: rtl/ifmp1_rr_pkg.sv
// Shared types and constants for the ifmp1 round-robin master.
//   IFMP1_DATA_W     : width of the ifmp1 data word (sig1)
//   IFMP1_TMR_W      : width of the saturating per-state timer
//   ifmp1_rr_state_e : controller FSM states
package ifmp1_rr_pkg;

  localparam int unsigned IFMP1_DATA_W = 32;
  localparam int unsigned IFMP1_TMR_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StRelease,
    StErr
  } ifmp1_rr_state_e;

endpackage

// File: rtl/ifmp1_rr_master_if.sv
// ifmp1 link: one data word driven by the master, one acknowledge from the slave.
//   sig1 : master -> slave, data word
//   sig2 : slave -> master, acknowledge (synchronous to the master clock)
interface ifmp1_rr_master_if;

  logic [ifmp1_rr_pkg::IFMP1_DATA_W-1:0] sig1;
  logic                                  sig2;

  modport master (output sig1, input sig2);
  modport slave  (input sig1, output sig2);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index where the search starts (must be < N_REQ)
//   o_gnt : one-hot winner, zero when no request is set
//   o_idx : winner index (don't care when no request is set)
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PW-1:0]    o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [PW:0]      w_j;
  logic [PW-1:0]    w_off;
  logic [PW:0]      w_sum;

  // Rotate so i_ptr lands at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    w_rot = '0;
    w_j   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_j = (PW+1)'(i) + {1'b0, i_ptr};
      if (w_j >= (PW+1)'(N_REQ)) w_j = w_j - (PW+1)'(N_REQ);
      w_rot[i] = i_req[w_j[PW-1:0]];
    end

    w_off = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end

    w_sum = {1'b0, w_off} + {1'b0, i_ptr};
    if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
    o_idx = w_sum[PW-1:0];

    o_gnt = '0;
    if (|i_req) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/ifmp1_rr_master.sv
// Round-robin owner of the ifmp1 master side, shared by N_REQ requesters.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req_valid   : per-requester request, held until granted
//   i_req_data    : per-requester word, stable while requesting
//   o_req_grant   : one-hot pulse, request accepted and word captured
//   o_req_done    : one-hot pulse, slave acknowledged
//   o_req_err     : one-hot pulse, transfer aborted by timeout
//   o_busy        : high whenever the FSM is not idle
//   ifmp1_m       : ifmp1 master modport (sig1 out, sig2 in)
// All outputs are registered.
module ifmp1_rr_master
  import ifmp1_rr_pkg::*;
#(
  parameter int unsigned              N_REQ       = 4,
  parameter int unsigned              TIMEOUT_CYC = 255,
  parameter logic [IFMP1_DATA_W-1:0]  IDLE_WORD   = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_REQ-1:0]                     i_req_valid,
  input  logic [N_REQ-1:0][IFMP1_DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]                     o_req_grant,
  output logic [N_REQ-1:0]                     o_req_done,
  output logic [N_REQ-1:0]                     o_req_err,
  output logic                                 o_busy,
  ifmp1_rr_master_if.master                    ifmp1_m
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam logic [IFMP1_TMR_W-1:0] TMO = IFMP1_TMR_W'(TIMEOUT_CYC);

  ifmp1_rr_state_e          r_state;
  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            r_idx;
  logic [IFMP1_TMR_W-1:0]   r_tmr;
  logic [IFMP1_DATA_W-1:0]  r_sig1;
  logic [N_REQ-1:0]         r_grant;
  logic [N_REQ-1:0]         r_done;
  logic [N_REQ-1:0]         r_err;
  logic                     r_busy;

  logic [N_REQ-1:0]         w_gnt;
  logic [PW-1:0]            w_idx;
  logic [PW-1:0]            w_ptr_nxt;
  logic [N_REQ-1:0]         w_idx_oh;
  logic                     w_tmo;
  logic                     w_ack;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_ptr_nxt = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_idx_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;
  assign w_tmo     = (r_tmr == TMO);
  assign w_ack     = ifmp1_m.sig2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_tmr   <= '0;
      r_sig1  <= IDLE_WORD;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        StIdle: begin
          if (|i_req_valid) begin
            r_state <= StDrive;
            r_sig1  <= i_req_data[w_idx];
            r_grant <= w_gnt;
            r_idx   <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_tmr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StDrive: begin
          // Acknowledge wins over a coincident timeout.
          if (w_ack) begin
            r_state <= StRelease;
            r_done  <= w_idx_oh;
            r_sig1  <= IDLE_WORD;
            r_tmr   <= '0;
          end else if (w_tmo) begin
            r_state <= StErr;
            r_err   <= w_idx_oh;
            r_sig1  <= IDLE_WORD;
            r_tmr   <= '0;
          end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        StRelease: begin
          if (!w_ack) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
          end else if (w_tmo) begin
            r_state <= StErr;
            r_err   <= w_idx_oh;
            r_tmr   <= '0;
          end else if (r_tmr != '1) begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        StErr: begin
          r_state <= StIdle;
          r_sig1  <= IDLE_WORD;
          r_busy  <= 1'b0;
          r_tmr   <= '0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_tmr   <= '0;
        end
      endcase
    end
  end

  assign o_req_grant  = r_grant;
  assign o_req_done   = r_done;
  assign o_req_err    = r_err;
  assign o_busy       = r_busy;
  assign ifmp1_m.sig1 = r_sig1;

endmodule

// File: tb/tb_ifmp1_rr_master.sv
// Scoreboard bench for ifmp1_rr_master (N_REQ=4, TIMEOUT_CYC=8, IDLE_WORD=0).
module tb_ifmp1_rr_master;

  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0][31:0] req_data = '0;
  logic [3:0]       grant, done, err;
  logic             busy;
  logic             echo = 1'b0;
  logic             sig2_drv = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;

  ifmp1_rr_master_if bus ();

  // Slave model: either a plain driven level or an echo of "sig1 is being driven".
  assign bus.sig2 = echo ? (bus.sig1 != 32'h0) : sig2_drv;

  ifmp1_rr_master #(
    .N_REQ       (4),
    .TIMEOUT_CYC (TMO),
    .IDLE_WORD   (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_grant (grant),
    .o_req_done  (done),
    .o_req_err   (err),
    .o_busy      (busy),
    .ifmp1_m     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 grant, 1 done, 2 err
    logic [3:0]  vec;
    logic [31:0] data;   // sig1 expected with a grant
    int          gap;    // cycles since previous event, -1 = don't care
  } exp_t;

  exp_t sb_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic void push(input int kind, input logic [3:0] vec, input logic [31:0] data,
                               input int gap);
    exp_t e;
    e.kind = kind;
    e.vec  = vec;
    e.data = data;
    e.gap  = gap;
    sb_q.push_back(e);
  endfunction

  // Monitor: pops one expectation per observed grant/done/err pulse.
  initial begin : monitor
    int   last_cyc;
    int   kind_act;
    int   n_act;
    exp_t e;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if ((grant | done | err) != 4'b0) begin
        n_act = int'(grant != 0) + int'(done != 0) + int'(err != 0);
        chk("single_event_kind", n_act, 1);
        chk("event_onehot", 32'($onehot(grant | done | err)), 1);
        kind_act = (grant != 0) ? 0 : ((done != 0) ? 1 : 2);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d vec %b required none", kind_act,
                   grant | done | err);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind", kind_act, e.kind);
          chk("event_vec", {28'h0, grant | done | err}, {28'h0, e.vec});
          if (e.gap >= 0) chk("event_gap", cyc - last_cyc, e.gap);
          if (e.kind == 0) chk("grant_sig1", bus.sig1, e.data);
        end
        last_cyc = cyc;
      end
    end
  end

  // Advance until no request is pending and the DUT is idle; drop each request once granted.
  task automatic run_until_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      req_valid &= ~grant;
      n++;
    end while ((req_valid != 0 || busy) && n < 200);
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle_timeout: got busy after %0d cycles required idle", nm, n);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ngr;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sig1", bus.sig1, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pulses", {20'h0, grant, done, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on 2, ack raised 3 cycles after grant, dropped 2 cycles later
    req_data[2] = 32'hDEADBEEF;
    req_valid   = 4'b0100;
    push(0, 4'b0100, 32'hDEADBEEF, -1);
    push(1, 4'b0100, 32'h0, 4);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("single_hold_sig1", bus.sig1, 32'hDEADBEEF);
    chk("single_busy", {31'h0, busy}, 32'h1);
    sig2_drv = 1'b1;
    @(posedge clk);
    #1;
    chk("single_sig1_after_done", bus.sig1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    sig2_drv = 1'b0;
    run_until_idle("single");
    chk("single_end_busy", {31'h0, busy}, 32'h0);
    chk("single_end_sig1", bus.sig1, 32'h0);

    // Reset in the middle of DRIVE (ptr is 3, so requester 1 wins)
    @(negedge clk);
    req_data[1] = 32'h1111_0001;
    req_valid   = 4'b0010;
    push(0, 4'b0010, 32'h1111_0001, -1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_sig1", bus.sig1, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_pulses", {20'h0, grant, done, err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_queue_empty", sb_q.size(), 0);
    @(negedge clk);

    // Fairness: all four requesting, slave echoes DRIVE; order 0,1,2,3,0,1 every 3 cycles
    echo = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 32'hA000_0000 + 32'(i);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      push(0, 4'b0001 << (i % 4), 32'hA000_0000 + 32'(i % 4), (i == 0) ? -1 : 2);
      push(1, 4'b0001 << (i % 4), 32'h0, 1);
    end
    ngr = 0;
    n = 0;
    while (ngr < 6 && n < 100) begin
      @(posedge clk);
      #1;
      if (grant != 0) ngr++;
      n++;
    end
    chk("fair_grant_count", ngr, 6);
    req_valid = 4'b0000;
    run_until_idle("fair");

    // Move ptr to 1 via a grant to 0, then only 3 and 0 requesting: 3 first, then 0
    @(negedge clk);
    req_data[0] = 32'hC0C0_0000;
    req_data[3] = 32'hC3C3_0003;
    req_valid   = 4'b0001;
    push(0, 4'b0001, 32'hC0C0_0000, -1);
    push(1, 4'b0001, 32'h0, 1);
    run_until_idle("skip_pre");
    @(negedge clk);
    req_valid = 4'b1001;
    push(0, 4'b1000, 32'hC3C3_0003, -1);
    push(1, 4'b1000, 32'h0, 1);
    push(0, 4'b0001, 32'hC0C0_0000, 2);
    push(1, 4'b0001, 32'h0, 1);
    run_until_idle("skip");
    chk("skip_queue_empty", sb_q.size(), 0);

    // DRIVE timeout: ack never comes; ptr is 1, so requester 2 wins
    echo     = 1'b0;
    sig2_drv = 1'b0;
    @(negedge clk);
    req_data[2] = 32'h2222_0002;
    req_valid   = 4'b0100;
    push(0, 4'b0100, 32'h2222_0002, -1);
    push(2, 4'b0100, 32'h0, TMO + 1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (TMO + 1) @(posedge clk);
    #1;
    chk("dto_err", {28'h0, err}, 32'h4);
    chk("dto_busy_in_err", {31'h0, busy}, 32'h1);
    chk("dto_sig1_in_err", bus.sig1, 32'h0);
    @(posedge clk);
    #1;
    chk("dto_idle_busy", {31'h0, busy}, 32'h0);
    chk("dto_idle_err", {28'h0, err}, 32'h0);

    // RELEASE timeout: ack stuck high; ptr is 3, so requester 1 wins
    sig2_drv = 1'b1;
    @(negedge clk);
    req_data[1] = 32'h3333_0001;
    req_valid   = 4'b0010;
    push(0, 4'b0010, 32'h3333_0001, -1);
    push(1, 4'b0010, 32'h0, 1);
    push(2, 4'b0010, 32'h0, TMO + 1);
    run_until_idle("rto");
    chk("rto_busy", {31'h0, busy}, 32'h0);
    chk("rto_sig1", bus.sig1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rto_stays_idle", {31'h0, busy}, 32'h0);
    sig2_drv = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_queue_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
